// File: rtl/morz_digit_tx.sv
// Morse transmitter for decimal digits: one digit per handshake, keyed out on M.
// Optional one-entry holding register is enabled with `define MORZ_TX_HOLD_EN.
module morz_digit_tx #(
  parameter int unsigned STROB_DIV  = 12500000,
  parameter int unsigned DOT_T      = 2,
  parameter int unsigned DASH_T     = 5,
  parameter int unsigned GAP_T      = 2,
  parameter int unsigned CHAR_GAP_T = 8
) (
  input  logic       C,
  input  logic       R,
  input  logic [3:0] D,
  input  logic       Start,
  output logic       Ready,
  output logic       M,
  output logic       Done,
  output logic       Err
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, CHARGAP} state_t;

  state_t      state, state_n;
  logic [4:0]  pat, pat_n;
  logic [2:0]  idx, idx_n;
  logic [23:0] presc, presc_n;
  logic [3:0]  dur, dur_n;
  logic        done_n, err_n;
  logic        tick, good, bad;
  logic [3:0]  mark_last;

  function automatic logic [4:0] digit_pat(input logic [3:0] d);
    case (d)
      4'd0:    digit_pat = 5'b11111;
      4'd1:    digit_pat = 5'b01111;
      4'd2:    digit_pat = 5'b00111;
      4'd3:    digit_pat = 5'b00011;
      4'd4:    digit_pat = 5'b00001;
      4'd5:    digit_pat = 5'b00000;
      4'd6:    digit_pat = 5'b10000;
      4'd7:    digit_pat = 5'b11000;
      4'd8:    digit_pat = 5'b11100;
      default: digit_pat = 5'b11110;
    endcase
  endfunction

  assign tick      = (presc == 24'(STROB_DIV - 1));
  assign good      = Start && (D <= 4'd9);
  assign bad       = Start && (D > 4'd9);
  // pat shifts left on each mark exit, so bit 4 is always the current element
  assign mark_last = pat[4] ? 4'(DASH_T - 1) : 4'(DOT_T - 1);

`ifdef MORZ_TX_HOLD_EN
  logic       hold_full, hold_full_n;
  logic [4:0] hold_pat, hold_pat_n;
  logic       take;

  assign take = good && !hold_full;

  always_comb Ready = !hold_full;

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      hold_full <= 1'b0;
      hold_pat  <= '0;
    end else begin
      hold_full <= hold_full_n;
      hold_pat  <= hold_pat_n;
    end
  end
`else
  always_comb Ready = (state == IDLE);
`endif

  always_comb begin
    state_n = state;
    pat_n   = pat;
    idx_n   = idx;
    done_n  = 1'b0;
    err_n   = 1'b0;
    presc_n = tick ? '0 : presc + 24'd1;
    dur_n   = tick ? dur + 4'd1 : dur;
`ifdef MORZ_TX_HOLD_EN
    hold_full_n = hold_full;
    hold_pat_n  = hold_pat;
    err_n       = bad;
    if (take && state != IDLE) begin
      hold_full_n = 1'b1;
      hold_pat_n  = digit_pat(D);
    end
`endif
    case (state)
      IDLE: begin
`ifdef MORZ_TX_HOLD_EN
        if (take) begin
`else
        err_n = bad;
        if (good) begin
`endif
          state_n = MARK;
          pat_n   = digit_pat(D);
          idx_n   = '0;
        end
      end
      MARK: begin
        if (tick && dur == mark_last) begin
          idx_n   = idx + 3'd1;
          pat_n   = {pat[3:0], 1'b0};
          state_n = (idx == 3'd4) ? CHARGAP : SPACE;
        end
      end
      SPACE: begin
        if (tick && dur == 4'(GAP_T - 1))
          state_n = MARK;
      end
      default: begin
        if (tick && dur == 4'(CHAR_GAP_T - 1)) begin
          done_n  = 1'b1;
          state_n = IDLE;
`ifdef MORZ_TX_HOLD_EN
          // Held digit (or one arriving on this very edge) launches without visiting IDLE
          if (hold_full || take) begin
            state_n     = MARK;
            pat_n       = hold_full ? hold_pat : digit_pat(D);
            idx_n       = '0;
            hold_full_n = 1'b0;
          end
`endif
        end
      end
    endcase
    if (state_n != state) begin
      presc_n = '0;
      dur_n   = '0;
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state <= IDLE;
      pat   <= '0;
      idx   <= '0;
      presc <= '0;
      dur   <= '0;
      M     <= 1'b0;
      Done  <= 1'b0;
      Err   <= 1'b0;
    end else begin
      state <= state_n;
      pat   <= pat_n;
      idx   <= idx_n;
      presc <= presc_n;
      dur   <= dur_n;
      M     <= (state_n == MARK);
      Done  <= done_n;
      Err   <= err_n;
    end
  end

endmodule

// File: tb/tb_morz_digit_tx.sv
// Directed bench for morz_digit_tx with STROB_DIV=4 (dot 8, dash 20, gap 8, char gap 32 clocks).
module tb_morz_digit_tx;

  logic       C = 1'b0;
  logic       R;
  logic       Start;
  logic [3:0] D;
  logic       Ready, M, Done, Err;

  int errors = 0;
  int checks = 0;

`ifdef MORZ_TX_HOLD_EN
  localparam int BUSY_READY = 1;
  localparam int HOLD = 1;
`else
  localparam int BUSY_READY = 0;
  localparam int HOLD = 0;
`endif

  morz_digit_tx #(
    .STROB_DIV (4),
    .DOT_T     (2),
    .DASH_T    (5),
    .GAP_T     (2),
    .CHAR_GAP_T(8)
  ) dut (
    .C    (C),
    .R    (R),
    .D    (D),
    .Start(Start),
    .Ready(Ready),
    .M    (M),
    .Done (Done),
    .Err  (Err)
  );

  always #5 C = ~C;

  typedef struct {
    logic [3:0] d;
    logic [4:0] pat;
    int         done_at;
    int         poke_at;
    logic [3:0] poke_d;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge on which Done rose.
  task automatic send_char(input logic [3:0] d, input logic [4:0] pat, input int done_at,
                           input int poke_at, input logic [3:0] poke_d);
    int runs[$];
    int n, len, ready_bad, exp_len;
    logic prev;
    string tag;
    tag = $sformatf("d%0d", d);
    Start = 1'b1;
    D = d;
    @(posedge C); #1;
    Start = 1'b0;
    D = 4'd0;
    n = 0;
    chk({tag, " m_at_accept"}, int'(M), 1);
    chk({tag, " done_low_at_accept"}, int'(Done), 0);
    prev = 1'b1;
    len = 1;
    ready_bad = 0;
    while (n < 400) begin
      if (n == poke_at) begin
        Start = 1'b1;
        D = poke_d;
      end
      @(posedge C); #1;
      n++;
      if (n == poke_at + 1) begin
        Start = 1'b0;
        D = 4'd0;
        chk({tag, " busy_err"}, int'(Err), (HOLD == 1 && poke_d > 4'd9) ? 1 : 0);
      end
      if (Done === 1'b1) break;
      if (int'(Ready) != BUSY_READY) ready_bad++;
      if (M !== prev) begin
        runs.push_back(len);
        len = 1;
        prev = M;
      end else begin
        len++;
      end
    end
    chk({tag, " done_at"}, n, done_at);
    chk({tag, " ready_at_done"}, int'(Ready), 1);
    chk({tag, " m_at_done"}, int'(M), 0);
    chk({tag, " ready_busy_bad"}, ready_bad, 0);
    chk({tag, " run_count"}, runs.size(), 9);
    for (int i = 0; i < 5; i++) begin
      exp_len = pat[4 - i] ? 20 : 8;
      chk($sformatf("%s mark%0d", tag, i), (2 * i < runs.size()) ? runs[2 * i] : -1, exp_len);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s space%0d", tag, i), (2 * i + 1 < runs.size()) ? runs[2 * i + 1] : -1, 8);
    chk({tag, " char_gap"}, len, 32);
  endtask

  initial begin
    int cnt;
    int n;
    int first_done;

    vecs[0] = '{4'd5, 5'b00000, 104, -1, 4'd0};
    vecs[1] = '{4'd0, 5'b11111, 164, 30, 4'd13};
    vecs[2] = '{4'd7, 5'b11000, 128, -1, 4'd0};
    vecs[3] = '{4'd1, 5'b01111, 152, -1, 4'd0};
    vecs[4] = '{4'd2, 5'b00111, 140, 100, 4'd15};
    vecs[5] = '{4'd3, 5'b00011, 128, -1, 4'd0};
    vecs[6] = '{4'd4, 5'b00001, 116, -1, 4'd0};
    vecs[7] = '{4'd6, 5'b10000, 116, -1, 4'd0};
    vecs[8] = '{4'd8, 5'b11100, 140, -1, 4'd0};
    vecs[9] = '{4'd9, 5'b11110, 152, -1, 4'd0};

    R = 1'b1;
    Start = 1'b0;
    D = 4'd0;
    #1;
    chk("reset_m", int'(M), 0);
    chk("reset_ready", int'(Ready), 1);
    chk("reset_done", int'(Done), 0);
    chk("reset_err", int'(Err), 0);
    repeat (2) @(posedge C);
    #1 R = 1'b0;
    @(posedge C); #1;

    // Table entries run back to back: each Start lands in the previous Done cycle.
    for (int i = 0; i < 10; i++)
      send_char(vecs[i].d, vecs[i].pat, vecs[i].done_at, vecs[i].poke_at, vecs[i].poke_d);

    // Out-of-range digit in IDLE.
    @(posedge C); #1;
    Start = 1'b1;
    D = 4'd12;
    @(posedge C); #1;
    Start = 1'b0;
    D = 4'd0;
    chk("err_pulse", int'(Err), 1);
    chk("err_m", int'(M), 0);
    chk("err_ready", int'(Ready), 1);
    @(posedge C); #1;
    chk("err_one_cycle", int'(Err), 0);
    cnt = 0;
    repeat (20) begin
      @(posedge C); #1;
      if (Done !== 1'b0 || M !== 1'b0 || Ready !== 1'b1) cnt++;
    end
    chk("err_no_effect", cnt, 0);

`ifndef MORZ_TX_HOLD_EN
    // Valid request while busy is ignored.
    send_char(4'd6, 5'b10000, 116, 40, 4'd2);
    @(posedge C); #1;
    chk("busy_ignored_idle", int'(M), 0);
`endif

    // Reset during the 4th mark of digit 3 (mark spans clocks 48..67).
    Start = 1'b1;
    D = 4'd3;
    @(posedge C); #1;
    Start = 1'b0;
    D = 4'd0;
    repeat (55) @(posedge C);
    #1;
    chk("rst_mid_m_before", int'(M), 1);
    #2 R = 1'b1;
    #1;
    chk("rst_mid_m_async", int'(M), 0);
    chk("rst_mid_ready", int'(Ready), 1);
    @(posedge C); #1;
    R = 1'b0;
    cnt = 0;
    repeat (150) begin
      @(posedge C); #1;
      if (Done !== 1'b0 || M !== 1'b0 || Ready !== 1'b1) cnt++;
    end
    chk("rst_quiet_after", cnt, 0);
    send_char(4'd3, 5'b00011, 128, -1, 4'd0);

`ifdef MORZ_TX_HOLD_EN
    // D=1 then D=9 ten clocks later: 9 is held and launches on the first Done edge.
    @(posedge C); #1;
    Start = 1'b1;
    D = 4'd1;
    @(posedge C); #1;
    Start = 1'b0;
    D = 4'd0;
    n = 0;
    cnt = 0;
    first_done = -1;
    while (n < 400) begin
      if (n == 10) begin
        Start = 1'b1;
        D = 4'd9;
      end
      @(posedge C); #1;
      n++;
      if (n == 11) begin
        Start = 1'b0;
        D = 4'd0;
        chk("hold_ready_low", int'(Ready), 0);
        chk("hold_no_err", int'(Err), 0);
      end
      if (Done === 1'b1 && first_done < 0) begin
        first_done = n;
        chk("hold_m_on_handoff", int'(M), 1);
        chk("hold_ready_after", int'(Ready), 1);
      end else if (Done === 1'b1) begin
        break;
      end else if (n > 11 && first_done < 0 && Ready !== 1'b0) begin
        cnt++;
      end
    end
    chk("hold_first_done", first_done, 152);
    chk("hold_second_done", n, 304);
    chk("hold_ready_while_full", cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
